// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Constants and types shared by the fetch front-end and the
//                pipelined core (NOP encoding, reset PC, fetch FSM states,
//                operation-type codes).
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Instruction presented to the core when no valid word is available
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    // Default first fetch address after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch front-end state machine
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Operation classes decoded by the core
    localparam logic [1:0] OP_ALU = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BEQ = 2'd2;
    localparam logic [1:0] OP_J   = 2'd3;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous prefetch FIFO holding {address, instruction}
//                pairs. Clear has priority over push and pop.
//  Ports       : clk, rst         - clock, asynchronous active-high reset
//                push_i / data_i  - write one entry
//                pop_i            - consume the head entry
//                clear_i          - discard all entries
//                occupancy_o      - number of stored entries (0..DEPTH)
//                empty_o          - no entries stored
//                head_o           - oldest entry (undefined when empty)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     empty_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam int unsigned   CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o     = (count_q == '0);
    assign pop_ok      = pop_i && !empty_o;
    // A push into a full FIFO is accepted only if the head leaves in the same cycle
    assign push_ok     = push_i && ((count_q != FULL) || pop_ok);
    assign occupancy_o = count_q;
    assign head_o      = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only visible through count_q
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Instruction fetch front-end. Issues word-aligned requests to
//                instruction memory, buffers in-order responses with their
//                addresses in a prefetch FIFO and presents them to the core.
//                Redirects flush the FIFO and drop in-flight stale responses.
//  Ports       : clk, rst                          - clock, async reset
//                imem_req_valid/addr/ready         - fetch request channel
//                imem_resp_valid/data              - in-order response channel
//                redirect_valid/addr               - core redirect pulse
//                stall                             - core holds its IF stage
//                inst_valid/instruction/inst_address - head word to the core
//  Revision    : 1.0  initial release
// ============================================================================
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_address
);

    localparam int unsigned   CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDIT_LIM = (CW + 1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] occupancy;
    logic          fifo_empty;
    logic [63:0]   fifo_head;
    logic [31:0]   redir_pc;
    logic [CW-1:0] outst_after_resp;
    logic          credit_ok;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (redirect_valid),
        .data_i      ({resp_pc_q, imem_resp_data}),
        .occupancy_o (occupancy),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    assign inst_valid    = !fifo_empty;
    assign instruction   = fifo_empty ? NOP_INST : fifo_head[31:0];
    assign inst_address  = fifo_empty ? 32'h0    : fifo_head[63:32];
    assign imem_req_addr = fetch_pc_q;
    assign pop           = inst_valid && !stall;

    always_comb begin
        redir_pc         = redirect_addr & ~32'h3;
        // Start-of-cycle occupancy: a same-cycle pop is ignored, which can
        // only under-issue and therefore never overflows the FIFO.
        credit_ok        = ({1'b0, occupancy} + {1'b0, outst_q}) < CREDIT_LIM;
        imem_req_valid   = (state_q == FETCH) && !redirect_valid && credit_ok;
        accept           = imem_req_valid && imem_req_ready;
        drop             = imem_resp_valid && (discard_q != '0);
        push             = imem_resp_valid && !drop && !redirect_valid;
        outst_after_resp = outst_q - CW'(imem_resp_valid);
        outst_d          = outst_after_resp + CW'(accept);

        fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = push   ? resp_pc_q  + 32'd4 : resp_pc_q;
        discard_d  = discard_q - CW'(drop);

        if (redirect_valid) begin
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            // Everything still in flight belongs to the old path
            discard_d  = outst_after_resp;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   state_d = (discard_d == '0) ? FETCH : DRAIN;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            state_d = (discard_d != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Self-checking bench for inst_fetch_unit. A behavioural
//                memory with programmable latency answers requests; expected
//                instruction streams are queued per scenario and a monitor
//                compares every word the core consumes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_address;

    inst_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .stall           (stall),
        .inst_valid      (inst_valid),
        .instruction     (instruction),
        .inst_address    (inst_address)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    lat     = 1;
    int    acc_cnt = 0;
    logic  mem_ready = 1'b1;
    logic [31:0] last_acc_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Queue n sequential words starting at start (address wraps mod 2^32)
    task automatic push_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = start + 32'(4 * i);
            e.data = e.addr ^ KEY;
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: called just after a rising edge, drives inputs for the
    // cycle, models the memory and returns just after the next rising edge.
    task automatic cycle(input logic redir, input logic [31:0] raddr);
        logic        acc;
        logic [31:0] acc_addr;
        logic        resp;
        redirect_valid = redir;
        redirect_addr  = redir ? raddr : 32'h0;
        stall          = (exp_q.size() == 0);
        imem_req_ready = mem_ready;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_q[0].addr ^ KEY;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        resp     = imem_resp_valid;
        @(posedge clk);
        cyc++;
        if (resp) void'(pend_q.pop_front());
        if (acc) begin
            pend_t p;
            p.addr = acc_addr;
            p.due  = cyc - 1 + lat;
            pend_q.push_back(p);
            acc_cnt++;
            last_acc_addr = acc_addr;
        end
        #1;
    endtask

    task automatic run_until_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: every consumed head word must match the next expected entry
    always @(negedge clk) begin
        if (!rst && inst_valid && !stall) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_inst: got addr 0x%08h data 0x%08h, required none",
                         inst_address, instruction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (inst_address !== e.addr || instruction !== e.data) begin
                    n_fail++;
                    $display("FAIL inst_stream: got addr 0x%08h data 0x%08h, required addr 0x%08h data 0x%08h",
                             inst_address, instruction, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        int          n;
        int          acc_before;
        logic [31:0] held;

        rst             = 1'b1;
        stall           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_addr   = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_inst_address", inst_address, 32'h0);

        // Reset release, 1-cycle memory, sequential stream from 0x0
        rst = 1'b0;
        #1;
        chk("idle_no_req", imem_req_valid, 0);
        cycle(1'b0, 32'h0);
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        push_exp(32'h0, 8);
        run_until_empty("seq_stream_timeout");

        // Stall held 10 cycles: credit limit stops requests, nothing lost
        acc_before = acc_cnt;
        repeat (10) cycle(1'b0, 32'h0);
        chk("stall_no_req", imem_req_valid, 0);
        chk("stall_credit", ((acc_cnt - acc_before) <= 4) ? 32'd1 : 32'd0, 1);
        chk("stall_head_addr", inst_address, 32'h20);
        push_exp(32'h20, 4);
        run_until_empty("stall_release_timeout");

        // Latency-3 memory, redirect to 0x40 with two requests outstanding
        lat = 3;
        cycle(1'b1, 32'h100);
        chk("redir_inst_valid_low", inst_valid, 0);
        n = 0;
        while (!(pend_q.size() == 2 && pend_q[0].addr == 32'h100 && pend_q[0].due > cyc) && n < 50) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        chk("two_outstanding_reached", (n < 50) ? 32'd1 : 32'd0, 1);
        acc_before = acc_cnt;
        cycle(1'b1, 32'h40);
        chk("redir40_inst_valid_low", inst_valid, 0);
        push_exp(32'h40, 4);
        n = 0;
        while (acc_cnt == acc_before && n < 30) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        chk("redir40_first_req", last_acc_addr, 32'h40);
        chk("redir40_drained", pend_q.size(), 1);
        run_until_empty("redir40_timeout");

        // Redirect to 0x80 in the same cycle as the response for 0x10
        cycle(1'b1, 32'h10);
        n = 0;
        while (!(pend_q.size() > 0 && pend_q[0].addr == 32'h10 && pend_q[0].due <= cyc) && n < 50) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        chk("resp10_reached", (n < 50) ? 32'd1 : 32'd0, 1);
        cycle(1'b1, 32'h80);
        chk("redir80_inst_valid_low", inst_valid, 0);
        push_exp(32'h80, 4);
        run_until_empty("redir80_timeout");

        // Request held stable while memory is not ready
        mem_ready = 1'b0;
        cycle(1'b1, 32'h200);
        n = 0;
        while (!imem_req_valid && n < 30) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        held = imem_req_addr;
        chk("notready_addr", held, 32'h200);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0);
            chk("notready_valid_held", imem_req_valid, 1);
            chk("notready_addr_held", imem_req_addr, held);
        end
        mem_ready = 1'b1;
        cycle(1'b0, 32'h0);
        chk("accept_advances_pc", imem_req_addr, held + 32'd4);
        push_exp(32'h200, 4);
        run_until_empty("notready_timeout");

        // Unaligned redirect near the top of memory: low bits dropped, PC wraps
        cycle(1'b1, 32'hFFFF_FFFB);
        push_exp(32'hFFFF_FFF8, 4);
        run_until_empty("wrap_timeout");

        // Reset with a full FIFO
        n = 0;
        while (!(inst_valid && !imem_req_valid && pend_q.size() == 0) && n < 50) begin
            cycle(1'b0, 32'h0);
            n++;
        end
        chk("fifo_full_reached", (n < 50) ? 32'd1 : 32'd0, 1);
        rst = 1'b1;
        #1;
        chk("midrst_req_valid", imem_req_valid, 0);
        chk("midrst_req_addr", imem_req_addr, 32'h0);
        chk("midrst_inst_valid", inst_valid, 0);
        chk("midrst_instruction", instruction, 32'h0);
        chk("midrst_inst_address", inst_address, 32'h0);
        pend_q.delete();
        imem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lat = 1;
        push_exp(32'h0, 4);
        run_until_empty("restart_timeout");

        repeat (3) cycle(1'b0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_inst_fetch_unit
`default_nettype wire
